fetch_prefetch_buffer: RTL and testbench
========================================

// Module: fetch_prefetch_buffer
// PURPOSE
//   Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
//   Issues sequential word fetches to a multi-cycle instruction memory over a req/ack handshake.
//   Buffers returned {pc, instr} pairs in a small FIFO and presents the head to IF/ID with valid/ready.
//   Flushes the FIFO and restarts fetch on a branch/flush redirect from ID.
// PARAMETERS
//   DEPTH     4       FIFO entries; power of two, >= 2
//   RESET_PC  32'h0   fetch address loaded at reset
// PORTS
//   clk_i          in   1   clock, all state on rising edge
//   rst_i          in   1   asynchronous, active-low reset
//   start_i        in   1   fetch enable; no new request issued while low
//   mem_req_o      out  1   request to instruction memory
//   mem_addr_o     out  32  word address of request
//   mem_ack_i      in   1   request complete; mem_rdata_i valid this cycle
//   mem_rdata_i    in   32  returned instruction word
//   redirect_i     in   1   branch taken / flush
//   redirect_pc_i  in   32  new fetch address, sampled when redirect_i=1
//   instr_valid_o  out  1   FIFO head valid
//   instr_o        out  32  head instruction; 32'h0000_0013 (NOP) when empty
//   pc_o           out  32  head PC; 32'h0 when empty
//   instr_ready_i  in   1   IF/ID accepts head (low = stall)
// BEHAVIOUR
//   Reset: count=0, rd/wr ptr=0, fetch_pc=RESET_PC, state=IDLE, mem_req_o=0, instr_valid_o=0.
//   Reset mid-request abandons the outstanding request; the memory drops it on reset.
//   FSM states:
//     IDLE: mem_req_o=0. Go to REQ when start_i & (count+pending < DEPTH).
//     REQ:  mem_req_o=1, mem_addr_o=fetch_pc.
//     DROP: mem_req_o=1, old address held. Waits for the ack, then discards the data.
//   Handshake:
//     mem_addr_o is stable while mem_req_o=1 until mem_ack_i.
//     mem_ack_i is only sampled while mem_req_o=1.
//     At most one request is outstanding. Earliest ack is the same cycle req rises.
//   REQ + ack, no redirect:
//     Push {fetch_pc, mem_rdata_i}; fetch_pc += 4, mod 2^32.
//     Stay in REQ if start_i and space remains after this push/pop; else go to IDLE.
//   Credit rule: a slot is reserved at request issue, so a push never overflows.
//     Push+pop in the same cycle leaves count unchanged.
//   Pop: instr_valid_o & instr_ready_i & ~redirect_i. Head advances next cycle.
//     instr_valid_o = (count != 0), registered-state derived; no combinational path from mem_ack_i.
//   Redirect (highest priority):
//     Next cycle: count=0, pointers reset, instr_valid_o=0, fetch_pc=redirect_pc_i.
//     Any pop in the redirect cycle is ignored.
//     REQ without ack -> DROP. REQ with ack in same cycle -> data discarded, go to REQ.
//     IDLE -> REQ. DROP -> stay in DROP, fetch_pc updated to the latest redirect_pc_i.
//   DROP + ack: discard data, go to REQ with fetch_pc (IDLE if start_i=0).
//   Latency: redirect to first new instr_valid_o = 2 cycles with a zero-wait memory.
//   Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//   start_i low: the outstanding request completes normally; the FIFO still drains.
// STRUCTURE
//   Shared package/include cpu_fetch_defs:
//     INSTR_NOP = 32'h0000_0013.
//     FETCH_IDLE / FETCH_REQ / FETCH_DROP 2-bit encodings.
//     PC_STEP = 32'd4.
//   Sub-module fetch_fifo: synchronous FIFO of DEPTH x 64b with push, pop, flush and count outputs.
//   The top level holds the FSM, fetch_pc and credit check.
// TESTING
//   1. Zero-wait memory (ack same cycle), ready=1, start_i=1 from reset:
//      pc_o sequence 0,4,8,12 on consecutive cycles; mem_rdata echoed in order.
//   2. ready=0 with DEPTH=4: exactly 4 acks accepted, then mem_req_o=0 with count=4.
//      Raise ready -> one pop per cycle and refetch resumes at PC 16.
//   3. 3-cycle memory latency, redirect_i with redirect_pc_i=32'h100 mid-request:
//      FSM enters DROP; the stale ack is discarded.
//      Next request addr=32'h100; first valid pc_o=32'h100.
//   4. Redirect and ack in the same cycle: acked word never appears at output.
//      FIFO empty next cycle; next mem_addr_o=redirect_pc_i.
//   5. Push+pop same cycle at count=DEPTH-1: count stays 3; order preserved across pointer wrap.
//   6. rst_i low mid-REQ: mem_req_o=0, instr_valid_o=0 immediately (asynchronous).
//      After release, first mem_addr_o=RESET_PC.

Source files
------------

// File: rtl/cpu_fetch_defs.sv
// rtl/cpu_fetch_defs.sv - shared fetch constants, FSM encoding and FIFO entry layout
package cpu_fetch_defs;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry {pc, instr} FIFO with flush and occupancy count
module fetch_fifo
   import cpu_fetch_defs::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t pushData,
   input  logic         pop,
   output fetch_entry_t headData,
   output logic [PW:0]  count
);

   fetch_entry_t   entries [DEPTH];
   logic [PW-1:0]  rdPtr;
   logic [PW-1:0]  wrPtr;

   // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop)  rdPtr <= rdPtr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) entries[wrPtr] <= pushData;
   end

   assign headData = entries[rdPtr];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - sequential instruction prefetcher feeding IF/ID
module fetch_prefetch_buffer
   import cpu_fetch_defs::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   input  logic        instr_ready_i
);

   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   fetch_state_e state, stateNext;
   logic [31:0]  fetchPc;
   logic [31:0]  heldAddr;
   logic [PW:0]  count;
   logic [PW:0]  countAfter;
   fetch_entry_t head;
   logic         ack, push, pop, spaceAfter;

   assign ack           = mem_req_o & mem_ack_i;
   assign instr_valid_o = (count != '0);
   assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;
   assign push          = (state == FETCH_REQ) & ack & ~redirect_i;
   assign countAfter    = count + (PW+1)'(push) - (PW+1)'(pop);
   assign spaceAfter    = countAfter < FULL;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= FETCH_IDLE;
         fetchPc  <= RESET_PC;
         heldAddr <= RESET_PC;
      end else begin
         state <= stateNext;
         if (redirect_i)  fetchPc <= redirect_pc_i;
         else if (push)   fetchPc <= fetchPc + PC_STEP;
         // The abandoned request keeps its address on the bus until memory acks it.
         if (state == FETCH_REQ && !ack && redirect_i) heldAddr <= fetchPc;
      end
   end

   // A redirect flushes the FIFO, so it always frees room for a new request.
   always_comb begin
      stateNext = state;
      case (state)
         FETCH_IDLE: begin
            if (start_i && (redirect_i || count < FULL)) stateNext = FETCH_REQ;
         end
         FETCH_REQ, FETCH_DROP: begin
            if (ack)
               stateNext = (start_i && (redirect_i || spaceAfter)) ? FETCH_REQ : FETCH_IDLE;
            else if (redirect_i)
               stateNext = FETCH_DROP;
         end
         default: stateNext = FETCH_IDLE;
      endcase
   end

   always_comb begin
      mem_req_o  = 1'b0;
      mem_addr_o = fetchPc;
      case (state)
         FETCH_REQ:  mem_req_o = 1'b1;
         FETCH_DROP: begin
            mem_req_o  = 1'b1;
            mem_addr_o = heldAddr;
         end
         default: ;
      endcase
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk_i),
      .rstN     (rst_i),
      .flush    (redirect_i),
      .push     (push),
      .pushData ('{pc: fetchPc, instr: mem_rdata_i}),
      .pop      (pop),
      .headData (head),
      .count    (count)
   );

   assign instr_o = instr_valid_o ? head.instr : INSTR_NOP;
   assign pc_o    = instr_valid_o ? head.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - randomized bench with queue reference model for the prefetcher
module tb_fetch_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memRdata;
   logic        redirect = 1'b0;
   logic [31:0] redirectPc = 32'h0;
   logic        instrValid;
   logic [31:0] instrOut;
   logic [31:0] pcOut;
   logic        ready = 1'b0;

   int nVec = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i         (clk),
      .rst_i         (rstN),
      .start_i       (start),
      .mem_req_o     (memReq),
      .mem_addr_o    (memAddr),
      .mem_ack_i     (memAck),
      .mem_rdata_i   (memRdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirectPc),
      .instr_valid_o (instrValid),
      .instr_o       (instrOut),
      .pc_o          (pcOut),
      .instr_ready_i (ready)
   );

   function automatic logic [31:0] rdataOf(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Instruction memory: fixed or random wait states, dropped on reset.
   int fixedLat = 0;
   int waitCnt;
   int curLat;

   function automatic int pickLat();
      return (fixedLat >= 0) ? fixedLat : int'($urandom_range(3));
   endfunction

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         waitCnt <= 0;
         curLat  <= pickLat();
      end else if (memReq) begin
         if (memAck) begin
            waitCnt <= 0;
            curLat  <= pickLat();
         end else begin
            waitCnt <= waitCnt + 1;
         end
      end
   end

   assign memAck   = memReq && (waitCnt >= curLat);
   assign memRdata = rdataOf(memAddr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of delivered words plus one outstanding-request record.
   logic [63:0] q[$];
   bit          mOut, mDisc;
   logic [31:0] mAddr, mPc;
   logic [31:0] popLog[$];
   logic [31:0] popInstrLog[$];
   logic [31:0] ackLog[$];

   initial begin
      forever begin
         @(posedge clk or negedge rstN);
         if (!rstN) begin
            q.delete();
            mOut = 0; mDisc = 0; mPc = RESET_PC; mAddr = RESET_PC;
         end else begin
            automatic bit ack  = memReq && memAck;
            automatic int szB  = q.size();
            automatic bit mPop = (q.size() != 0) && ready && !redirect;
            if (ack) ackLog.push_back(memAddr);
            if (instrValid && ready && !redirect) begin
               popLog.push_back(pcOut);
               popInstrLog.push_back(instrOut);
            end
            if (redirect) begin
               q.delete();
               mPc = redirectPc;
            end else begin
               if (ack && !mDisc) begin
                  q.push_back({mAddr, rdataOf(mAddr)});
                  mPc = mPc + 32'd4;
               end
               if (mPop) void'(q.pop_front());
            end
            if (mOut && !ack) begin
               if (redirect) mDisc = 1;
            end else begin
               automatic int sz = mOut ? q.size() : szB;
               mOut  = start && (redirect || sz < DEPTH);
               mDisc = 0;
               mAddr = mPc;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rstN) begin
            automatic bit ev = (q.size() != 0);
            check("valid", instrValid, ev);
            check("pc", pcOut, ev ? q[0][63:32] : 32'h0);
            check("instr", instrOut, ev ? q[0][31:0] : NOP);
            check("req", memReq, mOut);
            if (mOut) check("addr", memAddr, mAddr);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic applyReset(input int lat);
      fixedLat = lat;
      redirect = 1'b0;
      rstN = 1'b0;
      repeat (2) step();
      popLog.delete(); popInstrLog.delete(); ackLog.delete();
      rstN = 1'b1;
   endtask

   initial begin
      bit found;

      // Reset state
      repeat (2) step();
      check("rst_req", memReq, 1'b0);
      check("rst_valid", instrValid, 1'b0);
      check("rst_instr", instrOut, NOP);
      check("rst_pc", pcOut, 32'h0);

      // Zero-wait memory, always ready: back-to-back PCs with echoed data
      start = 1; ready = 1;
      applyReset(0);
      repeat (8) step();
      check("t1_pops", (popLog.size() >= 4), 1'b1);
      for (int i = 0; i < 4 && i < popLog.size(); i++) begin
         check("t1_pc", popLog[i], 32'(4 * i));
         check("t1_instr", popInstrLog[i], rdataOf(32'(4 * i)));
      end

      // Asynchronous reset in the middle of a request
      fixedLat = 2;
      check("t6_pre_req", memReq, 1'b1);
      #2 rstN = 1'b0;
      #1;
      check("t6_req", memReq, 1'b0);
      check("t6_valid", instrValid, 1'b0);
      applyReset(2);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         found = (ackLog.size() != 0);
      end
      check("t6_ack_seen", found, 1'b1);
      if (found) check("t6_first_addr", ackLog[0], RESET_PC);

      // Stalled consumer: FIFO fills, fetch stops, then drains and refetches at 16
      start = 1; ready = 0;
      applyReset(0);
      repeat (12) step();
      check("t2_acks", ackLog.size(), 32'd4);
      check("t2_req_off", memReq, 1'b0);
      check("t2_valid", instrValid, 1'b1);
      ready = 1;
      repeat (12) step();
      check("t2_pops", (popLog.size() >= 8), 1'b1);
      for (int i = 0; i < 8 && i < popLog.size(); i++) check("t2_order", popLog[i], 32'(4 * i));
      check("t2_acks2", (ackLog.size() >= 5), 1'b1);
      if (ackLog.size() >= 5) check("t2_refetch", ackLog[4], 32'd16);

      // 3-cycle memory, redirect while the request waits
      start = 1; ready = 1;
      applyReset(3);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         found = memReq && (waitCnt == 1);
      end
      check("t3_midreq", found, 1'b1);
      redirect = 1; redirectPc = 32'h100;
      step();
      redirect = 0;
      popLog.delete(); popInstrLog.delete();
      check("t3_drop_req", memReq, 1'b1);
      check("t3_drop_addr", memAddr, 32'h0);
      repeat (15) step();
      check("t3_acks", (ackLog.size() >= 2), 1'b1);
      if (ackLog.size() >= 2) check("t3_new_addr", ackLog[1], 32'h100);
      check("t3_pops", (popLog.size() >= 1), 1'b1);
      if (popLog.size() >= 1) check("t3_first_pc", popLog[0], 32'h100);

      // Redirect in the same cycle as an ack
      applyReset(0);
      repeat (4) step();
      check("t4_pre_ack", memReq && memAck, 1'b1);
      redirect = 1; redirectPc = 32'h200;
      step();
      redirect = 0;
      popLog.delete(); popInstrLog.delete();
      check("t4_valid", instrValid, 1'b0);
      check("t4_addr", memAddr, 32'h200);
      repeat (4) step();
      check("t4_pops", (popLog.size() >= 1), 1'b1);
      if (popLog.size() >= 1) check("t4_first_pc", popLog[0], 32'h200);

      // Random traffic against the model
      start = 1; ready = 1;
      applyReset(-1);
      for (int i = 0; i < 3000; i++) begin
         step();
         start      = ($urandom_range(9) != 0);
         ready      = ($urandom_range(9) < 7);
         redirect   = ($urandom_range(19) == 0);
         redirectPc = $urandom & 32'hFFFF_FFFC;
      end
      redirect = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
